dmem_requester: RTL and testbench

//  Initiator side of the data-memory port: accepts one load/store from the core,

---
 rtl/dmem_requester_pkg.sv | 13 +
 rtl/dmem_lane_align.sv | 37 +++
 rtl/dmem_requester.sv | 169 ++++++++++++++++
 tb/tb_dmem_requester.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_requester_pkg.sv
// rtl/dmem_requester_pkg.sv - shared size encodings and alignment helper for the data-memory requester
package dmem_requester_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Half needs an even address, word needs a 4-byte aligned address.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SIZE_H) && off[0]) || ((size == SIZE_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - store lane replication / byte select and load shift / extend
module dmem_lane_align (
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_bsv,
  output logic [31:0] o_rdata
);
  import dmem_requester_pkg::*;

  logic [31:0] w_shifted;

  // Replicate store data across lanes, build the byte mask, and right-justify/extend load data.
  always_comb begin
    w_shifted = i_rdata >> {i_off, 3'b000};
    o_wdata   = i_wdata;
    o_bsv     = 4'b1111;
    o_rdata   = w_shifted;
    case (i_size)
      SIZE_B: begin
        o_wdata = {4{i_wdata[7:0]}};
        o_bsv   = 4'b0001 << i_off;
        o_rdata = i_unsigned ? {24'h0, w_shifted[7:0]} : {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      SIZE_H: begin
        o_wdata = {2{i_wdata[15:0]}};
        o_bsv   = 4'b0011 << i_off;
        o_rdata = i_unsigned ? {16'h0, w_shifted[15:0]} : {{16{w_shifted[15]}}, w_shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_requester.sv
// rtl/dmem_requester.sv - single-outstanding load/store initiator for the word-addressed data memory
module dmem_requester #(
  parameter int ADDR_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_we,
  input  logic [ADDR_BITS-1:0] i_req_addr,
  input  logic [1:0]           i_req_size,
  input  logic                 i_req_unsigned,
  input  logic [31:0]          i_req_wdata,
  output logic                 o_rsp_valid,
  output logic                 o_rsp_err,
  output logic [31:0]          o_rsp_rdata,
  output logic [ADDR_BITS-3:0] o_mem_addr,
  output logic                 o_mem_ren,
  output logic                 o_mem_wen,
  output logic [31:0]          o_mem_wdata,
  output logic [3:0]           o_mem_bsv,
  input  logic [31:0]          i_mem_rdata,
  input  logic                 i_mem_ready
);
  import dmem_requester_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_RD_WAIT  = 2'd2,
    ST_WR_ISSUE = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [1:0]             r_size;
  logic [1:0]             r_off;
  logic                   r_unsigned;
  logic                   r_rsp_valid;
  logic                   r_rsp_err;
  logic [31:0]            r_rsp_rdata;
  logic [ADDR_BITS-3:0]   r_mem_addr;
  logic                   r_mem_ren;
  logic                   r_mem_wen;
  logic [31:0]            r_mem_wdata;
  logic [3:0]             r_mem_bsv;

  logic                   w_accept;
  logic                   w_misaligned;
  logic                   w_rsp_set;
  logic                   w_rsp_err_set;
  logic                   w_rd_capture;
  logic [1:0]             w_al_size;
  logic [1:0]             w_al_off;
  logic [31:0]            w_al_wdata;
  logic [3:0]             w_al_bsv;
  logic [31:0]            w_al_rdata;

  assign o_req_ready = (r_state == ST_IDLE);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_ren   = r_mem_ren;
  assign o_mem_wen   = r_mem_wen;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_bsv   = r_mem_bsv;

  // In IDLE the aligner sees the incoming request (store lanes); otherwise the latched load shape.
  assign w_al_size = (r_state == ST_IDLE) ? i_req_size      : r_size;
  assign w_al_off  = (r_state == ST_IDLE) ? i_req_addr[1:0] : r_off;

  dmem_lane_align u_align (
    .i_size     (w_al_size),
    .i_off      (w_al_off),
    .i_unsigned (r_unsigned),
    .i_wdata    (i_req_wdata),
    .i_rdata    (i_mem_rdata),
    .o_wdata    (w_al_wdata),
    .o_bsv      (w_al_bsv),
    .o_rdata    (w_al_rdata)
  );

  // Next state and response decisions; ready is ignored in RD_ISSUE since memory still shows idle.
  always_comb begin
    w_state_next  = r_state;
    w_accept      = i_req_valid && (r_state == ST_IDLE);
    w_misaligned  = is_misaligned(i_req_size, i_req_addr[1:0]);
    w_rsp_set     = 1'b0;
    w_rsp_err_set = 1'b0;
    w_rd_capture  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_misaligned) begin
            w_rsp_set     = 1'b1;
            w_rsp_err_set = 1'b1;
          end else if (i_req_we) begin
            w_state_next = ST_WR_ISSUE;
          end else begin
            w_state_next = ST_RD_ISSUE;
          end
        end
      end
      ST_RD_ISSUE: w_state_next = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (i_mem_ready) begin
          w_rsp_set    = 1'b1;
          w_rd_capture = 1'b1;
          w_state_next = ST_IDLE;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_rsp_set     = 1'b1;
          w_rsp_err_set = 1'b1;
          w_state_next  = ST_IDLE;
        end
      end
      ST_WR_ISSUE: begin
        w_rsp_set    = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State, timeout counter, latched request and registered memory/response outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_size      <= SIZE_B;
      r_off       <= 2'b00;
      r_unsigned  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_addr  <= '0;
      r_mem_ren   <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_wdata <= '0;
      r_mem_bsv   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_rsp_valid <= w_rsp_set;
      r_rsp_err   <= w_rsp_err_set;
      r_rsp_rdata <= w_rd_capture ? w_al_rdata : 32'h0;
      // Strobes follow the state being entered, so each is high for exactly that one state.
      r_mem_ren   <= (w_state_next == ST_RD_ISSUE);
      r_mem_wen   <= (w_state_next == ST_WR_ISSUE);
      if ((r_state == ST_RD_WAIT) && (w_state_next == ST_RD_WAIT)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
      if (w_accept && !w_misaligned) begin
        r_size      <= i_req_size;
        r_off       <= i_req_addr[1:0];
        r_unsigned  <= i_req_unsigned;
        r_mem_addr  <= i_req_addr[ADDR_BITS-1:2];
        r_mem_bsv   <= w_al_bsv;
        r_mem_wdata <= i_req_we ? w_al_wdata : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_requester.sv
// tb/tb_dmem_requester.sv - scoreboard bench for dmem_requester against a 7-cycle read memory model
module tb_dmem_requester;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [29:0] mem_addr;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_bsv;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int ren_count = 0;
  int wen_count = 0;
  int rsp_count = 0;
  logic hang = 1'b0;

  typedef struct { logic err; logic [31:0] rdata; int lat; int acc; } rsp_t;
  typedef struct { logic [29:0] addr; logic [3:0] bsv; logic [31:0] wdata; } wr_t;
  rsp_t        rsp_q[$];
  wr_t         wr_q[$];
  logic [29:0] rd_q[$];

  dmem_requester #(.ADDR_BITS(32), .TIMEOUT_CYCLES(64)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_we       (req_we),
    .i_req_addr     (req_addr),
    .i_req_size     (req_size),
    .i_req_unsigned (req_unsigned),
    .i_req_wdata    (req_wdata),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_err      (rsp_err),
    .o_rsp_rdata    (rsp_rdata),
    .o_mem_addr     (mem_addr),
    .o_mem_ren      (mem_ren),
    .o_mem_wen      (mem_wen),
    .o_mem_wdata    (mem_wdata),
    .o_mem_bsv      (mem_bsv),
    .i_mem_rdata    (mem_rdata),
    .i_mem_ready    (mem_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: ready drops after ren, data/ready appear so the requester samples them 7 edges later.
  logic [31:0] mem_words [0:63];
  int          rd_cnt;
  logic [5:0]  rd_idx;
  initial begin
    for (int i = 0; i < 64; i++) mem_words[i] = 32'h0;
    mem_words[0] = 32'h8123_4567;
  end
  always @(posedge clk) begin
    if (reset) begin
      mem_ready <= 1'b1;
      mem_rdata <= 32'h0;
      rd_cnt    <= 0;
      rd_idx    <= '0;
    end else begin
      if (mem_wen) begin
        for (int b = 0; b < 4; b++)
          if (mem_bsv[b]) mem_words[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      if (mem_ren) begin
        mem_ready <= 1'b0;
        mem_rdata <= 32'h0;
        rd_cnt    <= 6;
        rd_idx    <= mem_addr[5:0];
      end else if (rd_cnt > 0) begin
        rd_cnt <= rd_cnt - 1;
        if (rd_cnt == 1 && !hang) begin
          mem_ready <= 1'b1;
          mem_rdata <= mem_words[rd_idx];
        end
      end else if (mem_ready) begin
        mem_rdata <= 32'h0;
      end
    end
  end

  // Monitor: pops scoreboard entries on responses and memory strobes; protocol checks each cycle.
  logic prev_ren = 1'b0;
  logic prev_rsp = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid) begin
        rsp_count++;
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = rsp_q.pop_front();
          check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_latency", cyc - e.acc + 1, e.lat);
        end
        check("rsp_back_to_back", {31'h0, prev_rsp}, 32'd0);
      end
      if (mem_wen) begin
        wen_count++;
        if (wr_q.size() == 0) begin
          check("unexpected_wen", 32'd1, 32'd0);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", {2'b00, mem_addr}, {2'b00, w.addr});
          check("wr_bsv", {28'h0, mem_bsv}, {28'h0, w.bsv});
          check("wr_wdata", mem_wdata, w.wdata);
        end
      end
      if (mem_ren) begin
        ren_count++;
        if (rd_q.size() == 0) begin
          check("unexpected_ren", 32'd1, 32'd0);
        end else begin
          logic [29:0] a;
          a = rd_q.pop_front();
          check("rd_addr", {2'b00, mem_addr}, {2'b00, a});
        end
        check("ren_width", {31'h0, prev_ren}, 32'd0);
      end
      if (mem_ren || mem_wen) check("ren_and_wen", {31'h0, mem_ren & mem_wen}, 32'd0);
    end
    prev_ren = mem_ren;
    prev_rsp = rsp_valid;
  end

  task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata,
                      input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat,
                      input logic [3:0] exp_bsv, input logic [31:0] exp_wdata);
    rsp_t r;
    wr_t  w;
    int   g;
    @(negedge clk);
    g = 0;
    while (!req_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("req_ready_before_send", {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    r.err = exp_err; r.rdata = exp_rdata; r.lat = exp_lat; r.acc = cyc + 1;
    rsp_q.push_back(r);
    if (!exp_err || exp_lat > 1) begin
      if (we) begin
        w.addr = addr[31:2]; w.bsv = exp_bsv; w.wdata = exp_wdata;
        wr_q.push_back(w);
      end else begin
        rd_q.push_back(addr[31:2]);
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (rsp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (rsp_q.size() != 0) begin
      check("rsp_timeout", 32'd0, 32'd1);
      rsp_q.delete();
    end
  endtask

  task automatic st(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata,
                    input logic [3:0] bsv, input logic [31:0] lanes);
    send(1'b1, addr, size, 1'b0, wdata, 1'b0, 32'h0, 2, bsv, lanes);
    wait_done();
  endtask

  task automatic ld(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                    input logic [31:0] exp);
    send(1'b0, addr, size, uns, 32'h0, 1'b0, exp, 9, 4'h0, 32'h0);
    wait_done();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'h0, req_ready}, 32'd1);
    check({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'd0);
    check({tag, "_rsp_err"}, {31'h0, rsp_err}, 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    check({tag, "_mem_ren"}, {31'h0, mem_ren}, 32'd0);
    check({tag, "_mem_wen"}, {31'h0, mem_wen}, 32'd0);
    check({tag, "_mem_addr"}, {2'b00, mem_addr}, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check({tag, "_mem_bsv"}, {28'h0, mem_bsv}, 32'h0);
  endtask

  initial begin
    int r0;
    int w0;
    int c0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Word store then load; store byte to top lane, signed/unsigned reloads.
    st(32'h10, 2'b10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
    ld(32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
    st(32'h13, 2'b00, 32'h12345680, 4'b1000, 32'h80808080);
    ld(32'h13, 2'b00, 1'b0, 32'hFFFFFF80);
    ld(32'h13, 2'b00, 1'b1, 32'h00000080);
    ld(32'h11, 2'b00, 1'b1, 32'h000000BE);
    ld(32'h10, 2'b10, 1'b0, 32'h80ADBEEF);

    // Halfword extracts from the preloaded word 0x81234567.
    ld(32'h02, 2'b01, 1'b0, 32'hFFFF8123);
    ld(32'h02, 2'b01, 1'b1, 32'h00008123);
    ld(32'h00, 2'b01, 1'b0, 32'h00004567);

    // Misaligned half load and word store: error after one cycle, memory untouched.
    r0 = ren_count;
    send(1'b0, 32'h01, 2'b01, 1'b0, 32'h0, 1'b1, 32'h0, 1, 4'h0, 32'h0);
    wait_done();
    check("misaligned_no_ren", ren_count, r0);
    w0 = wen_count;
    send(1'b1, 32'h11, 2'b10, 1'b0, 32'hCAFEF00D, 1'b1, 32'h0, 1, 4'h0, 32'h0);
    wait_done();
    check("misaligned_no_wen", wen_count, w0);

    // Halfword store to upper lanes, reload as half and word.
    st(32'h06, 2'b01, 32'hAAAA1234, 4'b1100, 32'h12341234);
    ld(32'h06, 2'b01, 1'b1, 32'h00001234);
    ld(32'h04, 2'b10, 1'b0, 32'h12340000);

    // Memory never answers: timeout error, then recovery.
    hang = 1'b1;
    send(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0, 66, 4'h0, 32'h0);
    wait_done();
    hang = 1'b0;
    ld(32'h10, 2'b10, 1'b0, 32'h80ADBEEF);

    // Reset in RD_WAIT aborts without a response.
    send(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b0, 32'h80ADBEEF, 9, 4'h0, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rsp_q.delete();
    rd_q.delete();
    @(negedge clk);
    check_reset_outputs("abort");
    reset = 1'b0;
    c0 = rsp_count;
    repeat (15) @(negedge clk);
    check("abort_no_rsp", rsp_count, c0);
    ld(32'h10, 2'b10, 1'b0, 32'h80ADBEEF);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
